// File: rtl/regfile_pkg.sv
// Shared register-file types: address/data widths, the zero register and the
// queued write entry used by both the write queue and the register file.
package regfile_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [AW-1:0] wreg;
        logic [DW-1:0] data;
    } wq_entry_t;
endpackage

// File: rtl/regfile_wq_match.sv
// Youngest-first priority matcher over the write-queue entries; returns the
// data of the most recently pushed valid entry whose register equals i_addr.
module regfile_wq_match
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wq_entry_t [DEPTH-1:0] i_entries,
    input  logic [DEPTH-1:0]      i_valid,
    input  logic [PW-1:0]         i_wptr,
    input  logic [AW-1:0]         i_addr,
    output logic                  o_hit,
    output logic [DW-1:0]         o_data
);
    // Scan oldest to youngest so the last match (the youngest) is what remains.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            logic [PW-1:0] w_idx;
            w_idx = i_wptr - PW'(k);
            if (i_valid[w_idx] && i_entries[w_idx].wreg == i_addr && i_addr != REG_ZERO) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end
endmodule

// File: rtl/regfile_write_queue.sv
// Register-file write queue: FIFO of writeback requests drained one per cycle
// into the RF write port. Forwarding is built only with REGFILE_WQ_FWD_EN.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_reg,
    input  logic [DW-1:0]          in_data,
    input  logic                   drain_en,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    input  logic [AW-1:0]          rd_addr1,
    input  logic [AW-1:0]          rd_addr2,
    output logic                   fwd_hit1,
    output logic                   fwd_hit2,
    output logic [DW-1:0]          fwd_data1,
    output logic [DW-1:0]          fwd_data2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);
    import regfile_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wq_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic                  w_push;
    logic                  w_pop;

    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign in_ready = (r_count < CW'(DEPTH)) && !flush;
    assign rf_we    = drain_en && !empty;
    assign rf_waddr = empty ? '0 : r_mem[r_rptr].wreg;
    assign rf_wdata = empty ? '0 : r_mem[r_rptr].data;
    // Writes to r0 complete the handshake but never occupy an entry.
    assign w_push   = in_valid && in_ready && (in_reg != REG_ZERO);
    assign w_pop    = rf_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= '{wreg: in_reg, data: in_data};
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

`ifdef REGFILE_WQ_FWD_EN
    logic [DEPTH-1:0] w_vld;

    // Entry i is live when its distance from the head is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_vld
        logic [PW-1:0] w_dist;
        assign w_dist   = PW'(i) - r_rptr;
        assign w_vld[i] = ({1'b0, w_dist} < r_count);
    end

    regfile_wq_match #(.DEPTH(DEPTH)) u_match1 (
        .i_entries (r_mem),
        .i_valid   (w_vld),
        .i_wptr    (r_wptr),
        .i_addr    (rd_addr1),
        .o_hit     (fwd_hit1),
        .o_data    (fwd_data1)
    );

    regfile_wq_match #(.DEPTH(DEPTH)) u_match2 (
        .i_entries (r_mem),
        .i_valid   (w_vld),
        .i_wptr    (r_wptr),
        .i_addr    (rd_addr2),
        .o_hit     (fwd_hit2),
        .o_data    (fwd_data2)
    );
`else
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_regfile_write_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush, in_valid, in_ready, drain_en;
    logic [AW-1:0]          in_reg, rd_addr1, rd_addr2, rf_waddr;
    logic [DW-1:0]          in_data, rf_wdata, fwd_data1, fwd_data2;
    logic                   rf_we, fwd_hit1, fwd_hit2, empty;
    logic [$clog2(DEPTH):0] count;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .drain_en(drain_en), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count), .empty(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Youngest pending write to addr; the zero register never matches.
    task automatic ref_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef REGFILE_WQ_FWD_EN
        for (int i = 0; i < q.size(); i++)
            if (a != 0 && q[i].r == a) begin
                hit = 1'b1;
                d   = q[i].d;
            end
`endif
    endtask

    task automatic check_outputs();
        logic           h;
        logic [DW-1:0]  d;
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH && !flush));
        chk("rf_we", 64'(rf_we), 64'(drain_en && q.size() > 0));
        chk("rf_waddr", 64'(rf_waddr), q.size() > 0 ? 64'(q[0].r) : 64'd0);
        chk("rf_wdata", 64'(rf_wdata), q.size() > 0 ? 64'(q[0].d) : 64'd0);
        ref_fwd(rd_addr1, h, d);
        chk("fwd_hit1", 64'(fwd_hit1), 64'(h));
        chk("fwd_data1", 64'(fwd_data1), 64'(d));
        ref_fwd(rd_addr2, h, d);
        chk("fwd_hit2", 64'(fwd_hit2), 64'(h));
        chk("fwd_data2", 64'(fwd_data2), 64'(d));
    endtask

    // Drive one cycle, check before the edge, then advance the model on the edge.
    task automatic step(input logic f, input logic v, input logic [AW-1:0] r,
                        input logic [DW-1:0] d, input logic de,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        bit acc, pop;
        @(negedge clk);
        flush = f; in_valid = v; in_reg = r; in_data = d;
        drain_en = de; rd_addr1 = a1; rd_addr2 = a2;
        #1;
        check_outputs();
        acc = v && !f && q.size() < DEPTH;
        pop = de && q.size() > 0;
        @(posedge clk);
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc && r != 0) q.push_back('{r: r, d: d});
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 0; in_valid = 0; in_reg = 0; in_data = 0;
        drain_en = 0; rd_addr1 = 0; rd_addr2 = 0;
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single write with drain enabled commits the cycle after acceptance.
        step(0, 1, 5'd5, 32'hDEADBEEF, 1, 5'd5, 5'd0);
        step(0, 0, 5'd0, 32'h0, 1, 5'd5, 5'd0);
        step(0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0);

        // Fill, stall a fifth push, then drain in order.
        for (int i = 1; i <= 4; i++)
            step(0, 1, 5'(i), 32'h100 + i, 0, 5'd3, 5'd1);
        step(0, 1, 5'd9, 32'h999, 0, 5'd9, 5'd4);
        for (int i = 0; i < 5; i++)
            step(0, 0, 5'd0, 32'h0, 1, 5'd4, 5'd2);

        // r0 write is swallowed.
        step(0, 1, 5'd0, 32'h1234, 1, 5'd0, 5'd0);
        step(0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0);

        // Two writes to r7: youngest wins; rd_addr2 = 0 never hits.
        step(0, 1, 5'd7, 32'hA, 0, 5'd7, 5'd0);
        step(0, 1, 5'd7, 32'hB, 0, 5'd7, 5'd0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd7, 5'd0);
        step(0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0);
        step(0, 0, 5'd0, 32'h0, 1, 5'd7, 5'd0);

        // Flush with three queued and a concurrent request, then wrap pointers.
        for (int i = 0; i < 3; i++)
            step(0, 1, 5'(10 + i), 32'h200 + i, 0, 5'd11, 5'd12);
        step(1, 1, 5'd20, 32'h3333, 1, 5'd11, 5'd20);
        for (int i = 0; i < 6; i++)
            step(0, 1, 5'(21 + i), 32'h400 + i, 0, 5'd22, 5'd24);
        for (int i = 0; i < 3; i++)
            step(0, 1, 5'(27 + i), 32'h500 + i, 1, 5'd27, 5'd24);
        for (int i = 0; i < 6; i++)
            step(0, 0, 5'd0, 32'h0, 1, 5'd28, 5'd29);

        // Reset mid-drain drops rf_we without a clock edge.
        for (int i = 0; i < 3; i++)
            step(0, 1, 5'(1 + i), 32'h600 + i, 0, 5'd1, 5'd2);
        @(negedge clk);
        in_valid = 0; drain_en = 1;
        #1;
        chk("rf_we_pre_rst", 64'(rf_we), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rf_we_async_rst", 64'(rf_we), 64'd0);
        chk("count_async_rst", 64'(count), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic over a narrow register range to exercise matches.
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 19) == 0, 1'($urandom), 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 2) != 0,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
